hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the IF/ID and ID/EX stage registers. It detects load-use
//  hazards, flushes on taken branches, and holds EX while a multi-cycle multiply runs.
//  It drives the PC write enable, the IF/ID write/flush controls, the ID/EX stall,
//  and the control-bubble mux select that zeroes the ID/EX control inputs.
//  It also keeps a saturating count of stall and flush cycles for performance work.
// PARAMETERS
//  MUL_LAT  4   EX occupancy of a multiply, in cycles; legal range 1..16
//  CNT_W    16  width of each performance counter
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  reset         in   1      synchronous, active-high reset
//  id_rs         in   5      rs field of the instruction in ID
//  id_rt         in   5      rt field of the instruction in ID
//  id_uses_rt    in   1      instruction in ID reads rt as a source
//  id_mul        in   1      instruction in ID is a multi-cycle multiply
//  ex_rt         in   5      rt (load destination) of the instruction in EX
//  ex_MemRead    in   1      instruction in EX is a load
//  branch_taken  in   1      branch resolved taken in EX, this cycle
//  pc_write      out  1      PC update enable
//  if_id_write   out  1      IF/ID load enable
//  if_id_flush   out  1      IF/ID clear to NOP
//  id_ex_stall   out  1      ID/EX hold (drives the stage register's stall input)
//  id_ex_bubble  out  1      select zeroed control signals into ID/EX
//  mul_busy      out  1      FSM is in state MUL
//  stall_cnt     out  CNT_W  saturating count of cycles with pc_write=0
//  flush_cnt     out  CNT_W  saturating count of taken-branch flushes
// BEHAVIOUR
//  Clocking and reset
//  - One clock; reset is synchronous and active-high. Reset forces state=RUN,
//    mul_cnt=0, stall_cnt=0, flush_cnt=0.
//  - While reset is high, outputs take RUN/no-event values: pc_write=1, if_id_write=1,
//    all other 1-bit outputs 0.
//  Hazard terms (combinational)
//  - lu = ex_MemRead & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  - Register $0 never causes a hazard.
//  FSM outputs are combinational from state and current inputs (zero latency).
//  State RUN, evaluated in priority order:
//  - branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_cnt++;
//    remain in RUN. The branch takes priority over lu and id_mul.
//  - else lu: pc_write=0, if_id_write=0, id_ex_bubble=1 (one bubble); stay in RUN.
//    The hazard clears next cycle.
//  - else id_mul & MUL_LAT>1: the multiply issues normally this cycle.
//    Next state is MUL, with mul_cnt=MUL_LAT-1.
//  - else: pc_write=1, if_id_write=1, all others 0.
//  State MUL:
//  - pc_write=0, if_id_write=0, id_ex_stall=1, mul_busy=1.
//  - mul_cnt decrements each cycle; when mul_cnt==1 the next state is RUN.
//  - The net effect is exactly MUL_LAT-1 stall cycles.
//  - branch_taken, lu and id_mul are ignored in MUL; branch_taken=1 there is a
//    protocol error (bench asserts).
//  - MUL_LAT=1: MUL is never entered.
//  Counters:
//  - stall_cnt increments on every non-reset cycle with pc_write=0.
//  - flush_cnt increments per taken-branch cycle in RUN.
//  - Both saturate at 2^CNT_W-1 (no wrap).
//  - reset mid-MUL: RUN on the next cycle, no residual stall.
// TESTING
//  1. EX lw $5; ID add $6,$5,$7 -> one cycle pc_write=0, if_id_write=0,
//     id_ex_bubble=1; normal next cycle; stall_cnt=1.
//  2. EX lw $0; ID uses $0 -> no stall (pc_write=1, bubble=0).
//  3. branch_taken=1 with lu=1 at the same time -> if_id_flush=1, bubble=1,
//     pc_write=1; flush_cnt=1, stall_cnt=0.
//  4. MUL_LAT=4, id_mul pulse -> mul_busy/id_ex_stall high exactly 3 cycles,
//     then RUN; stall_cnt=3.
//  5. id_mul with lu simultaneously -> 1 load-use bubble first; MUL entered
//     on the next cycle's issue (total 1+3 stalls).
//  6. reset asserted on 2nd MUL cycle -> next cycle pc_write=1, mul_busy=0,
//     counters=0; CNT_W=4 forced 20 stalls -> stall_cnt=15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bus: ID/EX hazard inputs toward the sequencer and the
// stage-register controls plus performance counters coming back.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_mul;
  logic [4:0]       ex_rt;
  logic             ex_MemRead;
  logic             branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_bubble;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_mul, ex_rt, ex_MemRead, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_stall, id_ex_bubble, mul_busy,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_mul, ex_rt, ex_MemRead, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_stall, id_ex_bubble, mul_busy,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// IF/ID and ID/EX pipeline sequencer: load-use bubbles, taken-branch flushes,
// multi-cycle multiply hold, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);
  localparam logic [0:0]       ST_RUN   = 1'b0;
  localparam logic [0:0]       ST_MUL   = 1'b1;
  localparam logic [4:0]       MUL_INIT = 5'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [4:0]       r_mul_cnt;
  logic [4:0]       w_mul_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_lu;
  logic             w_flush_evt;
  logic             w_pc_write;
  logic             w_if_id_write;
  logic             w_if_id_flush;
  logic             w_id_ex_stall;
  logic             w_id_ex_bubble;
  logic             w_mul_busy;

  // Load-use hazard; a load into $0 never stalls.
  assign w_lu = bus.ex_MemRead & (bus.ex_rt != 5'd0) &
                ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));

  // Next-state and zero-latency control outputs; reset forces the RUN/no-event values.
  always_comb begin
    w_state_nxt    = r_state;
    w_mul_cnt_nxt  = r_mul_cnt;
    w_flush_evt    = 1'b0;
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_mul_busy     = 1'b0;
    if (reset) begin
      w_state_nxt   = ST_RUN;
      w_mul_cnt_nxt = 5'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.branch_taken) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
            w_flush_evt    = 1'b1;
          end else if (w_lu) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
          end else if (bus.id_mul && (MUL_LAT > 1)) begin
            // The multiply issues this cycle; the hold starts next cycle.
            w_state_nxt   = ST_MUL;
            w_mul_cnt_nxt = MUL_INIT;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_MUL: begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_id_ex_stall = 1'b1;
          w_mul_busy    = 1'b1;
          if (r_mul_cnt <= 5'd1) begin
            w_state_nxt   = ST_RUN;
            w_mul_cnt_nxt = 5'd0;
          end else begin
            w_mul_cnt_nxt = r_mul_cnt - 5'd1;
          end
        end
        default: begin
          w_state_nxt   = ST_RUN;
          w_mul_cnt_nxt = 5'd0;
        end
      endcase
    end
  end

  // State, multiply countdown and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_mul_cnt   <= 5'd0;
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
      if (!w_pc_write && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_flush_evt && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_stall  = w_id_ex_stall;
  assign bus.id_ex_bubble = w_id_ex_bubble;
  assign bus.mul_busy     = w_mul_busy;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance (MUL_LAT=4, CNT_W=16) and a
// narrow instance (MUL_LAT=1, CNT_W=4) for saturation and the no-MUL case.
module tb_hazard_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hazard_ctrl_if #(.CNT_W(16)) hif ();
  hazard_ctrl_if #(.CNT_W(4))  hif4 ();

  hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  hazard_ctrl #(.MUL_LAT(1), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (hif4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driving branch_taken while a multiply holds EX is a protocol error.
  always @(negedge clk) begin
    #2;
    if (hif.mul_busy === 1'b1 && hif.branch_taken === 1'b1) begin
      $error("protocol violation: branch_taken during multiply");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                     input logic mul, input logic [4:0] exrt, input logic memrd,
                     input logic br);
    hif.id_rs        = rs;
    hif.id_rt        = rt;
    hif.id_uses_rt   = uses;
    hif.id_mul       = mul;
    hif.ex_rt        = exrt;
    hif.ex_MemRead   = memrd;
    hif.branch_taken = br;
  endtask

  task automatic drv4(input logic [4:0] rs, input logic mul, input logic [4:0] exrt,
                      input logic memrd, input logic br);
    hif4.id_rs        = rs;
    hif4.id_rt        = 5'd0;
    hif4.id_uses_rt   = 1'b0;
    hif4.id_mul       = mul;
    hif4.ex_rt        = exrt;
    hif4.ex_MemRead   = memrd;
    hif4.branch_taken = br;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drv(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
    drv4(5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Reset: events on the inputs must not leak through
    @(negedge clk); #1;
    chk("rst_pc_write", 32'(hif.pc_write), 32'd1);
    chk("rst_if_id_write", 32'(hif.if_id_write), 32'd1);
    chk("rst_flush", 32'(hif.if_id_flush), 32'd0);
    chk("rst_bubble", 32'(hif.id_ex_bubble), 32'd0);
    chk("rst_stall", 32'(hif.id_ex_stall), 32'd0);
    chk("rst_busy", 32'(hif.mul_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("rst_stall_cnt", 32'(hif.stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(hif.flush_cnt), 32'd0);
    chk("idle_pc_write", 32'(hif.pc_write), 32'd1);

    // 1: lw $5 in EX, add $6,$5,$7 in ID
    @(negedge clk); drv(5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0); #1;
    chk("t1_pc_write", 32'(hif.pc_write), 32'd0);
    chk("t1_if_id_write", 32'(hif.if_id_write), 32'd0);
    chk("t1_bubble", 32'(hif.id_ex_bubble), 32'd1);
    @(negedge clk); drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk("t1_next_pc_write", 32'(hif.pc_write), 32'd1);
    chk("t1_next_bubble", 32'(hif.id_ex_bubble), 32'd0);
    chk("t1_stall_cnt", 32'(hif.stall_cnt), 32'd1);

    // rt match counts only when ID actually reads rt
    @(negedge clk); drv(5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0); #1;
    chk("rt_use_pc_write", 32'(hif.pc_write), 32'd0);
    @(negedge clk); drv(5'd1, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0); #1;
    chk("rt_nouse_pc_write", 32'(hif.pc_write), 32'd1);
    chk("rt_stall_cnt", 32'(hif.stall_cnt), 32'd2);

    // 2: load into $0 never stalls
    @(negedge clk); drv(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0); #1;
    chk("t2_pc_write", 32'(hif.pc_write), 32'd1);
    chk("t2_bubble", 32'(hif.id_ex_bubble), 32'd0);

    // 3: branch wins over a simultaneous load-use
    @(negedge clk); drv(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1); #1;
    chk("t3_flush", 32'(hif.if_id_flush), 32'd1);
    chk("t3_bubble", 32'(hif.id_ex_bubble), 32'd1);
    chk("t3_pc_write", 32'(hif.pc_write), 32'd1);
    @(negedge clk); drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk("t3_flush_cnt", 32'(hif.flush_cnt), 32'd1);
    chk("t3_stall_cnt", 32'(hif.stall_cnt), 32'd2);
    chk("t3_flush_clear", 32'(hif.if_id_flush), 32'd0);

    // 4: multiply holds EX for MUL_LAT-1 = 3 cycles; ID events are ignored meanwhile
    @(negedge clk); drv(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk("t4_issue_pc_write", 32'(hif.pc_write), 32'd1);
    chk("t4_issue_busy", 32'(hif.mul_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) drv(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
      else drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("t4_busy", 32'(hif.mul_busy), 32'd1);
      chk("t4_stall", 32'(hif.id_ex_stall), 32'd1);
      chk("t4_pc_write", 32'(hif.pc_write), 32'd0);
      chk("t4_bubble", 32'(hif.id_ex_bubble), 32'd0);
    end
    @(negedge clk); drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk("t4_done_busy", 32'(hif.mul_busy), 32'd0);
    chk("t4_done_pc_write", 32'(hif.pc_write), 32'd1);
    chk("t4_stall_cnt", 32'(hif.stall_cnt), 32'd5);

    // 5: multiply behind a load-use: one bubble, then issue, then 3 hold cycles
    @(negedge clk); drv(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0); #1;
    chk("t5_lu_pc_write", 32'(hif.pc_write), 32'd0);
    chk("t5_lu_bubble", 32'(hif.id_ex_bubble), 32'd1);
    chk("t5_lu_busy", 32'(hif.mul_busy), 32'd0);
    @(negedge clk); drv(5'd5, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk("t5_issue_pc_write", 32'(hif.pc_write), 32'd1);
    chk("t5_issue_busy", 32'(hif.mul_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
      chk("t5_busy", 32'(hif.mul_busy), 32'd1);
    end
    @(negedge clk); #1;
    chk("t5_done_busy", 32'(hif.mul_busy), 32'd0);
    chk("t5_stall_cnt", 32'(hif.stall_cnt), 32'd9);

    // 6: reset on the second MUL cycle
    @(negedge clk); drv(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    @(negedge clk); drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk("t6_mul1_busy", 32'(hif.mul_busy), 32'd1);
    @(negedge clk); reset = 1'b1; #1;
    chk("t6_rst_busy", 32'(hif.mul_busy), 32'd0);
    chk("t6_rst_pc_write", 32'(hif.pc_write), 32'd1);
    @(negedge clk); reset = 1'b0; #1;
    chk("t6_after_busy", 32'(hif.mul_busy), 32'd0);
    chk("t6_after_pc_write", 32'(hif.pc_write), 32'd1);
    chk("t6_after_stall_cnt", 32'(hif.stall_cnt), 32'd0);
    chk("t6_after_flush_cnt", 32'(hif.flush_cnt), 32'd0);
    @(negedge clk); #1;
    chk("t6_no_residual", 32'(hif.pc_write), 32'd1);

    // CNT_W=4: 20 forced stall cycles saturate at 15
    @(negedge clk); drv4(5'd3, 1'b0, 5'd3, 1'b1, 1'b0); #1;
    chk("sat_pc_write", 32'(hif4.pc_write), 32'd0);
    repeat (13) @(negedge clk);
    #1;
    chk("sat_cnt13", 32'(hif4.stall_cnt), 32'd13);
    repeat (6) @(negedge clk);
    @(negedge clk); drv4(5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk("sat_cnt15", 32'(hif4.stall_cnt), 32'd15);
    @(negedge clk); drv4(5'd0, 1'b0, 5'd0, 1'b0, 1'b1); #1;
    chk("sat_flush", 32'(hif4.if_id_flush), 32'd1);
    @(negedge clk); drv4(5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk("sat_flush_cnt", 32'(hif4.flush_cnt), 32'd1);
    chk("sat_hold15", 32'(hif4.stall_cnt), 32'd15);

    // MUL_LAT=1: a multiply never enters MUL
    @(negedge clk); drv4(5'd0, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk("lat1_issue_pc_write", 32'(hif4.pc_write), 32'd1);
    @(negedge clk); drv4(5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk("lat1_busy", 32'(hif4.mul_busy), 32'd0);
    chk("lat1_pc_write", 32'(hif4.pc_write), 32'd1);
    chk("lat1_stall", 32'(hif4.id_ex_stall), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
